instr_queue: RTL
================

// Module: instr_queue
// PURPOSE
//   Decoupling instruction queue between fetch and decode. Accepts {instr, PC+4} pairs
//   from the fetch unit and buffers them in a small FIFO. Hands them to decode under a
//   valid/ready handshake. Drives the fetch Stall input while full. Discards all buffered
//   entries on a branch/jump redirect.
// PARAMETERS
//   DEPTH  4   entries; power of two, >=2
//   AW     2   pointer width, log2(DEPTH)
// PORTS
//   clk         in   1   rising-edge clock
//   reset       in   1   asynchronous, active-high; clears all state
//   in_valid    in   1   fetch presents a valid instruction this cycle
//   in_instr    in   32  fetched instruction word
//   in_pc4      in   32  PC+4 of that instruction
//   fetch_stall out  1   to fetch Stall input; =full (hold PC)
//   flush       in   1   redirect (taken branch/jump); squash queue contents
//   out_valid   out  1   head entry valid for decode
//   out_instr   out  32  head instruction; 32'h0 (nop) when out_valid=0
//   out_pc4     out  32  head PC+4; 32'h0 when out_valid=0
//   out_ready   in   1   decode accepts head this cycle (=!decode stall)
//   count       out  AW+1 occupancy, 0..DEPTH
// BEHAVIOUR
//   - Reset: wr_ptr=rd_ptr=0, count=0, all storage 0; out_valid=0, out_instr=0, out_pc4=0, fetch_stall=0.
//   - Storage: DEPTH x 64-bit regs; pointers wrap modulo DEPTH (DEPTH-1 -> 0).
//   - full = (count==DEPTH); empty = (count==0); fetch_stall = full (registered state only; no comb path from out_ready).
//   - push = in_valid & !full & !flush; pop = out_valid & out_ready.
//   - Push at edge: mem[wr_ptr]<={in_instr,in_pc4}, wr_ptr++. Pop at edge: rd_ptr++.
//   - count: +1 push only, -1 pop only, unchanged on both or neither.
//   - Push when full: push is not performed; entry stays with fetch, which holds PC via fetch_stall.
//   - Simultaneous pop at full: pop done; push refused that cycle; fetch_stall drops next cycle.
//   - Simultaneous push+pop at count=1: both occur; count stays 1; new entry becomes head.
//   - out_valid = !empty & !flush. Head is read combinationally from mem[rd_ptr] (first-word fall-through).
//   - Push-to-out_valid latency: 1 cycle.
//   - flush (highest priority after reset): next edge wr_ptr=rd_ptr=0, count=0.
//     Same-cycle push and pop are suppressed; out_valid forced 0 during flush cycle.
//   - Reset asserted mid-operation: state cleared immediately (async). Outputs are 0 until the first push after release.
// CONFIGURATION
//   IQ_BYPASS_EN defined:
//     - when empty & in_valid & out_ready & !flush, in_instr/in_pc4 drive out_* combinationally with out_valid=1 (zero latency).
//     - Entry is consumed, not written; count stays 0.
//     - If out_ready=0, normal push.
//   IQ_BYPASS_EN undefined:
//     - no bypass; out_valid only from stored entries; 1-cycle minimum latency.
// TESTING
//   1 reset: assert reset mid-stream with count=3 -> count=0, out_valid=0, out_instr=0 same cycle, fetch_stall=0.
//   2 fill: out_ready=0, push 32'h3c010001,32'h34210002,32'h00221820,32'hac030000 (pc4 3004..3010)
//     -> count=4, fetch_stall=1; 5th in_valid not stored.
//   3 drain order: from state 2, out_ready=1 for 4 cycles -> out_instr 3c010001,34210002,00221820,ac030000
//     with out_pc4 3004,3008,300c,3010 in order; then out_valid=0, out_instr=0.
//   4 concurrent: count=1, push 32'h10220003 + pop same cycle -> count=1, head=10220003.
//     Run 10 push+pop cycles -> pointers wrap, FIFO order preserved.
//   5 flush: count=3, flush=1 with in_valid=1 -> out_valid=0 that cycle; next cycle count=0, nothing stored.
//     Following push of 32'h0c000c00 appears as head.
//   6 bypass: empty, in_valid=1, out_ready=1, in_instr=32'h24080005.
//     With IQ_BYPASS_EN -> out_valid=1 same cycle, count stays 0.
//     Without -> out_valid=0, next cycle out_valid=1 with 24080005.

Source files
------------

// File: rtl/instr_queue.sv
// Decoupling instruction queue between fetch and decode: a DEPTH-entry FIFO of {instr, pc4}
// with first-word fall-through, full-driven fetch stall and flush. Optional zero-latency bypass: IQ_BYPASS_EN.
module instr_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_pc4,
  output logic          fetch_stall,
  input  logic          flush,
  output logic          out_valid,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc4,
  input  logic          out_ready,
  output logic [AW:0]   count
);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          stored_valid;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  assign full         = (count == (AW+1)'(DEPTH));
  assign empty        = (count == '0);
  assign fetch_stall  = full;
  assign stored_valid = !empty && !flush;
  assign head         = mem[rd_ptr];

`ifdef IQ_BYPASS_EN
  // An empty queue with a ready consumer hands the fetched word straight through.
  assign bypass = empty && in_valid && out_ready && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign push = in_valid && !full && !flush && !bypass;
  assign pop  = stored_valid && out_ready;

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    out_valid = stored_valid || bypass;
    out_instr = '0;
    out_pc4   = '0;
    if (bypass) begin
      out_instr = in_instr;
      out_pc4   = in_pc4;
    end else if (stored_valid) begin
      out_instr = head[63:32];
      out_pc4   = head[31:0];
    end
  end

  // NOTE: storage is reset along with the pointers so every entry reads 0 after reset;
  // state updates use non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_instr, in_pc4};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
